// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: run-time pattern/length/overlap, registered
// one-cycle match pulse and a saturating match counter.
module seq_detect_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int COUNT_W = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               y,
    output logic [COUNT_W-1:0] match_count
);

    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] ALL_ONES  = '1;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               y_q, y_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        pattern_d  = pattern_q;
        len_d      = len_q;
        overlap_d  = overlap_q;
        y_d        = 1'b0;
        count_d    = count_q;
        match      = 1'b0;

        hist_shift = {hist_q[MAX_LEN-2:0], x};
        fill_inc   = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);
        // Shifting by len_q == MAX_LEN empties the ones, so the mask covers every bit.
        len_mask   = ~(ALL_ONES << len_q);

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (x_valid) begin
            match  = (len_q != '0) && (fill_inc >= len_q) &&
                     ((hist_shift & len_mask) == (pattern_q & len_mask));
            hist_d = hist_shift;
            fill_d = (match && !overlap_q) ? '0 : fill_inc;
            y_d    = match;
        end

        if (count_clr) begin
            count_d = '0;
        end else if (match && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            y_q       <= 1'b0;
            count_q   <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            y_q       <= y_d;
            count_q   <= count_d;
        end
    end

    assign y           = y_q;
    assign match_count = count_q;

endmodule
